// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the host-side requesters/config master and uart_tx_scheduler.
interface uart_tx_scheduler_if #(
    parameter int NREQ = 4
);
    logic              cfg_we;
    logic [3:0]        cfg_sel;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              Tx;
    logic              busy;
    logic [3:0]        cur_sel;
    logic              cfg_err;

    modport master (
        output cfg_we, cfg_sel, req, data,
        input  gnt, done, Tx, busy, cur_sel, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_sel, req, data,
        output gnt, done, Tx, busy, cur_sel, cfg_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter with an internal baud enable derived from the system clock.
// Defining UART_PARITY_EN inserts an even-parity bit between the data bits and the stop bit(s).
module uart_tx_scheduler #(
    parameter int NREQ      = 4,
    parameter int BASE_DIV  = 16,
    parameter int CNT_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int SUM_W = PTR_W + 1;
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_bitLen;
    logic [CNT_W-1:0] w_bitLast;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_owner;
    logic [PTR_W-1:0] r_ptr;
    logic [3:0]       r_curSel;
    logic             r_cfgErr;
`ifdef UART_PARITY_EN
    logic             r_parity;
`endif

    logic [PTR_W-1:0] w_winner;
    logic [NREQ-1:0]  w_winnerOh;
    logic [7:0]       w_winnerByte;
    logic [SUM_W-1:0] w_idx;
    logic             w_anyReq;
    logic             w_bitEnd;
    logic             w_grant;
    logic             w_advance;
    logic             w_loadCfg;
    logic             w_rejectCfg;
    logic [NREQ-1:0]  w_done;
    logic             w_tx;

    // Bit period is fixed by cur_sel, which can only change while idle.
    assign w_bitLen     = CNT_W'(BASE_DIV) * (CNT_W'(r_curSel) + CNT_W'(1));
    assign w_bitLast    = w_bitLen - CNT_W'(1);
    assign w_bitEnd     = (r_cnt == w_bitLast);
    assign w_winnerOh   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_winnerByte = bus.data[{w_winner, 3'b000} +: 8];

    // Walk downward so the nearest requester after the pointer is the last one written.
    always_comb begin
        w_anyReq = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = {1'b0, r_ptr} + SUM_W'(k);
            if (w_idx >= SUM_W'(NREQ)) begin
                w_idx = w_idx - SUM_W'(NREQ);
            end
            if (bus.req[w_idx[PTR_W-1:0]]) begin
                w_anyReq = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_advance   = 1'b0;
        w_loadCfg   = 1'b0;
        w_rejectCfg = 1'b0;
        w_done      = '0;
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_we) begin
                    w_loadCfg = 1'b1;
                end else if (w_anyReq) begin
                    w_grant     = 1'b1;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bitEnd) begin
                    w_advance   = 1'b1;
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bitEnd) begin
                    w_advance = 1'b1;
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_nextState = S_PAR;
`else
                        w_nextState = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PAR: begin
                w_tx = r_parity;
                if (w_bitEnd) begin
                    w_advance   = 1'b1;
                    w_nextState = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bitEnd) begin
                    w_advance = 1'b1;
                    if (r_bitIdx == STOP_LAST) begin
                        w_done      = r_owner;
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (r_state != S_IDLE && bus.cfg_we) begin
            w_rejectCfg = 1'b1;
        end
    end

    // Bit index doubles as the stop-bit counter; it clears whenever the state changes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_ptr    <= PTR_W'(NREQ - 1);
            r_curSel <= '0;
            r_cfgErr <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_cfgErr <= w_rejectCfg;
            if (w_loadCfg) begin
                r_curSel <= bus.cfg_sel;
            end
            if (w_grant) begin
                r_gnt    <= w_winnerOh;
                r_owner  <= w_winnerOh;
                r_ptr    <= w_winner;
                r_shift  <= w_winnerByte;
                r_cnt    <= '0;
                r_bitIdx <= '0;
            end else if (w_advance) begin
                r_cnt    <= '0;
                r_bitIdx <= (w_nextState == r_state) ? r_bitIdx + 3'd1 : 3'd0;
                if (r_state == S_DATA) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_parity <= 1'b0;
        end else if (w_grant) begin
            r_parity <= ^w_winnerByte;
        end
    end
`endif

    assign bus.gnt     = r_gnt;
    assign bus.done    = Rst ? '0 : w_done;
    assign bus.Tx      = w_tx;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.cur_sel = r_curSel;
    assign bus.cfg_err = r_cfgErr;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler: reset, framing, round-robin, config and abort.
module tb_uart_tx_scheduler;
    localparam int NREQ      = 4;
    localparam int BASE_DIV  = 16;
    localparam int STOP_BITS = 1;

    logic clk;
    logic rst;
    int   compCount;
    int   errCount;

    uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

    uart_tx_scheduler #(
        .NREQ(NREQ),
        .BASE_DIV(BASE_DIV),
        .CNT_W(16),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] reqVal, input logic cfgWe, input logic [3:0] cfgSel);
        bus.req     = reqVal;
        bus.cfg_we  = cfgWe;
        bus.cfg_sel = cfgSel;
    endtask

    task automatic waitGrant(input string tag, input logic [NREQ-1:0] expGnt, input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == '0 && n < maxCycles);
        checkOutput(tag, 32'(bus.gnt), 32'(expGnt));
    endtask

    // Entered at the grant-cycle negedge; returns at the negedge of the first idle cycle.
    task automatic checkFrame(input logic [7:0] byteVal, input int bitLen, input int owner,
                              input logic [3:0] selExp, input int cfgAt);
        logic [15:0]     bits;
        logic [NREQ-1:0] ownerOh;
        logic [NREQ-1:0] expDone;
        logic [NREQ-1:0] expGnt;
        logic            expErr;
        int              nBits;
        int              cyc;
        ownerOh = NREQ'(1) << owner;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = byteVal[i];
        nBits = 9;
`ifdef UART_PARITY_EN
        bits[9] = ^byteVal;
        nBits   = 10;
`endif
        nBits = nBits + STOP_BITS;
        cyc   = 0;
        for (int b = 0; b < nBits; b++) begin
            for (int c = 0; c < bitLen; c++) begin
                expDone = (b == nBits - 1 && c == bitLen - 1) ? ownerOh : '0;
                expGnt  = (cyc == 0) ? ownerOh : '0;
                expErr  = (cfgAt >= 0 && cyc == cfgAt + 1);
                checkOutput("frame Tx", 32'(bus.Tx), 32'(bits[b]));
                checkOutput("frame busy", 32'(bus.busy), 32'd1);
                checkOutput("frame gnt/done", 32'({bus.gnt, bus.done}), 32'({expGnt, expDone}));
                checkOutput("frame cfg_err/cur_sel", 32'({bus.cfg_err, bus.cur_sel}), 32'({expErr, selExp}));
                if (cfgAt >= 0 && cyc == cfgAt) begin
                    bus.cfg_we  = 1'b1;
                    bus.cfg_sel = 4'd7;
                end else begin
                    bus.cfg_we = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("end busy", 32'(bus.busy), 32'd0);
        checkOutput("end Tx", 32'(bus.Tx), 32'd1);
        checkOutput("end gnt/done", 32'({bus.gnt, bus.done}), 32'd0);
    endtask

    initial begin
        compCount = 0;
        errCount  = 0;
        bus.data  = '0;
        applyStimulus(4'b0000, 1'b0, 4'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: line high, nothing granted, default baud select.
        for (int i = 0; i < 50; i++) begin
            checkOutput("idle outputs", 32'({bus.Tx, bus.busy, bus.gnt, bus.done, bus.cur_sel, bus.cfg_err}),
                        32'({1'b1, 1'b0, 4'b0, 4'b0, 4'd0, 1'b0}));
            @(negedge clk);
        end

        bus.data[8*2 +: 8] = 8'hA5;
        applyStimulus(4'b0100, 1'b0, 4'd0);
        waitGrant("single gnt", 4'b0100, 1);
        bus.req[2] = 1'b0;
        checkFrame(8'hA5, 16, 2, 4'd0, -1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.data[8*0 +: 8] = 8'h11;
        bus.data[8*1 +: 8] = 8'h22;
        bus.data[8*3 +: 8] = 8'h33;
        applyStimulus(4'b1011, 1'b0, 4'd0);
        waitGrant("rr gnt 0", 4'b0001, 1);
        bus.req[0] = 1'b0;
        checkFrame(8'h11, 16, 0, 4'd0, -1);
        waitGrant("rr gnt 1", 4'b0010, 1);
        bus.req[1] = 1'b0;
        checkFrame(8'h22, 16, 1, 4'd0, -1);
        waitGrant("rr gnt 3", 4'b1000, 1);
        bus.req[3] = 1'b0;
        checkFrame(8'h33, 16, 3, 4'd0, -1);

        applyStimulus(4'b0000, 1'b1, 4'd3);
        @(negedge clk);
        checkOutput("cfg idle", 32'({bus.cur_sel, bus.cfg_err, bus.gnt}), 32'({4'd3, 1'b0, 4'b0}));
        bus.data[8*1 +: 8] = 8'h3C;
        applyStimulus(4'b0010, 1'b0, 4'd3);
        waitGrant("cfg gnt", 4'b0010, 1);
        bus.req[1] = 1'b0;
        checkFrame(8'h3C, 64, 1, 4'd3, 100);

        // Config and request together: config wins this cycle, grant follows with the new period.
        bus.data[8*3 +: 8] = 8'h5A;
        applyStimulus(4'b1000, 1'b1, 4'd1);
        @(negedge clk);
        checkOutput("simul cfg", 32'({bus.cur_sel, bus.gnt}), 32'({4'd1, 4'b0}));
        bus.cfg_we = 1'b0;
        waitGrant("simul gnt", 4'b1000, 1);
        bus.req[3] = 1'b0;
        checkFrame(8'h5A, 32, 3, 4'd1, -1);

        bus.data[8*1 +: 8] = 8'h0F;
        applyStimulus(4'b0010, 1'b0, 4'd0);
        waitGrant("abort gnt", 4'b0010, 1);
        bus.req[1] = 1'b0;
        repeat (5 * 32 + 3) @(negedge clk);
        checkOutput("abort bit4", 32'({bus.Tx, bus.busy}), 32'({1'b0, 1'b1}));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort reset", 32'({bus.Tx, bus.busy, bus.gnt, bus.done, bus.cur_sel}),
                    32'({1'b1, 1'b0, 4'b0, 4'b0, 4'd0}));
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("post abort", 32'({bus.Tx, bus.busy, bus.done}), 32'({1'b1, 1'b0, 4'b0}));
        end

        bus.data[8*0 +: 8] = 8'h07;
        bus.data[8*2 +: 8] = 8'hC3;
        applyStimulus(4'b0101, 1'b0, 4'd0);
        waitGrant("after reset gnt 0", 4'b0001, 1);
        bus.req[0] = 1'b0;
        checkFrame(8'h07, 16, 0, 4'd0, -1);
        waitGrant("held gnt 2", 4'b0100, 1);
        bus.req[2] = 1'b0;
        checkFrame(8'hC3, 16, 2, 4'd0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end
endmodule
